// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds opcode values, FSM state codes, ALU/PC/operand-B select codes,
// the decoded instruction class, and the bundled control-output struct.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] BSRC_B       = 2'b00;
  localparam logic [1:0] BSRC_FOUR    = 2'b01;
  localparam logic [1:0] BSRC_IMM     = 2'b10;
  localparam logic [1:0] BSRC_IMM_SH2 = 2'b11;

  typedef enum logic [2:0] {
    CLS_R, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_IMM, CLS_ILL
  } instr_cls_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_sel;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

endpackage

// File: rtl/mips_main_decoder.sv
// Opcode classifier for the main control FSM.
//   opcode  in  6  IR[31:26]
//   cls     out    instruction class (CLS_ILL for anything unsupported)
//   ext_sel out 1  1 = zero-extend imm16 (andi/ori), 0 = sign-extend
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output instr_cls_e cls,
  output logic       ext_sel
);

  always_comb begin
    cls     = CLS_ILL;
    ext_sel = 1'b0;
    case (opcode)
      OP_R:    cls = CLS_R;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      OP_ADDI: cls = CLS_IMM;
      OP_ANDI: begin cls = CLS_IMM; ext_sel = 1'b1; end
      OP_ORI:  begin cls = CLS_IMM; ext_sel = 1'b1; end
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, drives all datapath
// selects and enables, and handshakes with the unified memory via mem_ready
// with an optional per-access wait timeout (MEM_TIMEOUT, 0 = disabled).
// Inputs : clk, reset (async, active high), opcode[5:0], zero, mem_ready
// Outputs: memory (mem_read, mem_write, i_or_d), IR/PC (ir_write, pc_en,
//          pc_source), ALU (alu_src_a, alu_src_b, alu_op, ext_sel),
//          regfile (reg_dst, mem_to_reg, reg_write), status pulses
//          (illegal_op, mem_timeout) and debug state[3:0].
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_sel,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  instr_cls_e    cls;
  logic          dec_ext;
  logic          in_mem, limit_hit;
  ctrl_t         c;

  mips_main_decoder u_dec (
    .opcode  (opcode),
    .cls     (cls),
    .ext_sel (dec_ext)
  );

  assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);
  assign limit_hit = (MEM_TIMEOUT > 0) && in_mem && !mem_ready && (cnt_q == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c       = '0;
    c.ext_sel = dec_ext && (state_q != S_FETCH);

    case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = BSRC_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PC_ALU;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_en    = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch target computed into ALUOut.
        c.alu_src_b = BSRC_IMM_SH2;
        c.alu_op    = ALU_ADD;
        case (cls)
          CLS_LW, CLS_SW:   state_d = S_MEM_ADDR;
          CLS_R:            state_d = S_R_EXEC;
          CLS_BEQ, CLS_BNE: state_d = S_BRANCH;
          CLS_J:            state_d = S_JUMP;
          CLS_IMM:          state_d = S_I_EXEC;
          default: begin
            c.illegal_op = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = BSRC_IMM;
        c.alu_op    = ALU_ADD;
        if (cls == CLS_SW)      state_d = S_MEM_WRITE;
        else if (cls == CLS_LW) state_d = S_MEM_READ;
        else                    state_d = S_FETCH;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = BSRC_B;
        c.alu_op    = ALU_FUNCT;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = BSRC_B;
        c.alu_op    = ALU_SUB;
        c.pc_source = PC_ALUOUT;
        c.pc_en     = (cls == CLS_BEQ) ? zero : ~zero;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        c.pc_source = PC_JUMP;
        c.pc_en     = 1'b1;
        state_d     = S_FETCH;
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = BSRC_IMM;
        c.alu_op    = ALU_IMM;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        c.reg_write = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Wait counter only runs while a memory state is stalled; every other
    // path leaves it at zero, which doubles as the clear-on-entry.
    cnt_d = '0;
    if (in_mem && !mem_ready) begin
      if (limit_hit) begin
        // Abandon the access: no write, no PC/IR update, restart at FETCH.
        c.mem_timeout = 1'b1;
        c.mem_write   = 1'b0;
        c.ir_write    = 1'b0;
        c.pc_en       = 1'b0;
        state_d       = S_FETCH;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // All outputs forced low while reset is held.
  assign mem_read    = c.mem_read    & ~reset;
  assign mem_write   = c.mem_write   & ~reset;
  assign i_or_d      = c.i_or_d      & ~reset;
  assign ir_write    = c.ir_write    & ~reset;
  assign pc_en       = c.pc_en       & ~reset;
  assign pc_source   = reset ? 2'b00 : c.pc_source;
  assign alu_src_a   = c.alu_src_a   & ~reset;
  assign alu_src_b   = reset ? 2'b00 : c.alu_src_b;
  assign alu_op      = reset ? 2'b00 : c.alu_op;
  assign ext_sel     = c.ext_sel     & ~reset;
  assign reg_dst     = c.reg_dst     & ~reset;
  assign mem_to_reg  = c.mem_to_reg  & ~reset;
  assign reg_write   = c.reg_write   & ~reset;
  assign illegal_op  = c.illegal_op  & ~reset;
  assign mem_timeout = c.mem_timeout & ~reset;
  assign state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_en, alu_src_a;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       ext_sel, reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout;
  logic [3:0] state;

  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .ext_sel(ext_sel), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] val;
    logic [21:0] mask;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // {mr,mw,iod,irw,pce,pcs[2],asa,asb[2],aop[2],ext,rdst,m2r,rw,ill,to,st[4]}
  function automatic logic [21:0] ov(logic mr, logic mw, logic iod, logic irw, logic pce,
                                     logic [1:0] pcs, logic asa, logic [1:0] asb,
                                     logic [1:0] aop, logic ext, logic rdst, logic m2r,
                                     logic rw, logic ill, logic to, logic [3:0] st);
    return {mr, mw, iod, irw, pce, pcs, asa, asb, aop, ext, rdst, m2r, rw, ill, to, st};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a, alu_src_b,
            alu_op, ext_sel, reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout, state};
  endfunction

  localparam logic [21:0] ALL    = 22'h3FFFFF;
  localparam logic [21:0] NO_MW  = 22'h2FFFFF;
  logic [21:0] ZERO, F1, F0, D0, D1, DILL, MA, MR, MWB, MW, MWTO, REX, RWB, BRT, BRN, JMP, IEX, IWB;

  initial begin
    ZERO = '0;
    F1   = ov(1,0,0,1,1,2'd0,0,2'd1,2'd0,0,0,0,0,0,0,4'd0);
    F0   = ov(1,0,0,0,0,2'd0,0,2'd1,2'd0,0,0,0,0,0,0,4'd0);
    D0   = ov(0,0,0,0,0,2'd0,0,2'd3,2'd0,0,0,0,0,0,0,4'd1);
    D1   = ov(0,0,0,0,0,2'd0,0,2'd3,2'd0,1,0,0,0,0,0,4'd1);
    DILL = ov(0,0,0,0,0,2'd0,0,2'd3,2'd0,0,0,0,0,1,0,4'd1);
    MA   = ov(0,0,0,0,0,2'd0,1,2'd2,2'd0,0,0,0,0,0,0,4'd2);
    MR   = ov(1,0,1,0,0,2'd0,0,2'd0,2'd0,0,0,0,0,0,0,4'd3);
    MWB  = ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,1,1,0,0,4'd4);
    MW   = ov(0,1,1,0,0,2'd0,0,2'd0,2'd0,0,0,0,0,0,0,4'd5);
    MWTO = ov(0,0,1,0,0,2'd0,0,2'd0,2'd0,0,0,0,0,0,1,4'd5);
    REX  = ov(0,0,0,0,0,2'd0,1,2'd0,2'd2,0,0,0,0,0,0,4'd6);
    RWB  = ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1,0,1,0,0,4'd7);
    BRT  = ov(0,0,0,0,1,2'd1,1,2'd0,2'd1,0,0,0,0,0,0,4'd8);
    BRN  = ov(0,0,0,0,0,2'd1,1,2'd0,2'd1,0,0,0,0,0,0,4'd8);
    JMP  = ov(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,0,0,0,0,0,4'd9);
    IEX  = ov(0,0,0,0,0,2'd0,1,2'd2,2'd3,1,0,0,0,0,0,4'd10);
    IWB  = ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,0,1,0,0,4'd11);
  end

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [21:0] got;
      e   = q.pop_front();
      got = dut_vec();
      n_vec++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL %s: got %06h expected %06h (mask %06h)", e.name, got, e.val, e.mask);
      end
    end
  end

  task automatic cyc(input logic rst, input logic rdy, input logic z, input logic [21:0] v,
                     input logic [21:0] m, input string nm);
    exp_t e;
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    e.val = v; e.mask = m; e.name = nm;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    opcode = 6'b100011;
    // reset held 3 cycles with mem_ready high
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, ZERO, ALL, "reset_outputs");

    // lw, zero-wait
    cyc(0, 1, 0, F1,  ALL, "lw_fetch");
    cyc(0, 1, 0, D0,  ALL, "lw_decode");
    cyc(0, 1, 0, MA,  ALL, "lw_memaddr");
    cyc(0, 1, 0, MR,  ALL, "lw_memread");
    cyc(0, 1, 0, MWB, ALL, "lw_memwb");

    // beq taken
    opcode = 6'b000100;
    cyc(0, 1, 1, F1,  ALL, "beq_fetch");
    cyc(0, 1, 1, D0,  ALL, "beq_decode");
    cyc(0, 1, 1, BRT, ALL, "beq_branch");
    // bne with zero=1: not taken
    opcode = 6'b000101;
    cyc(0, 1, 1, F1,  ALL, "bne_fetch");
    cyc(0, 1, 1, D0,  ALL, "bne_decode");
    cyc(0, 1, 1, BRN, ALL, "bne_branch");

    // ori: zero-extend through I_WB
    opcode = 6'b001101;
    cyc(0, 1, 0, F1,  ALL, "ori_fetch");
    cyc(0, 1, 0, D1,  ALL, "ori_decode");
    cyc(0, 1, 0, IEX, ALL, "ori_iexec");
    cyc(0, 1, 0, IWB, ALL, "ori_iwb");

    // R-type, with fetch stalled two cycles
    opcode = 6'b000000;
    cyc(0, 0, 0, F0,  ALL, "r_fetch_wait");
    cyc(0, 0, 0, F0,  ALL, "r_fetch_wait");
    cyc(0, 1, 0, F1,  ALL, "r_fetch");
    cyc(0, 1, 0, D0,  ALL, "r_decode");
    cyc(0, 1, 0, REX, ALL, "r_exec");
    cyc(0, 1, 0, RWB, ALL, "r_wb");

    // jump
    opcode = 6'b000010;
    cyc(0, 1, 0, F1,  ALL, "j_fetch");
    cyc(0, 1, 0, D0,  ALL, "j_decode");
    cyc(0, 1, 0, JMP, ALL, "j_jump");

    // sw with 5 wait cycles
    opcode = 6'b101011;
    cyc(0, 1, 0, F1,  ALL, "sw_fetch");
    cyc(0, 1, 0, D0,  ALL, "sw_decode");
    cyc(0, 1, 0, MA,  ALL, "sw_memaddr");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, MW, ALL, "sw_wait");
    cyc(0, 1, 0, MW,  ALL, "sw_done");

    // sw with mem_ready never asserted: timeout on the 16th wait cycle
    cyc(0, 1, 0, F1,  ALL, "swto_fetch");
    cyc(0, 1, 0, D0,  ALL, "swto_decode");
    cyc(0, 1, 0, MA,  ALL, "swto_memaddr");
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, MW, ALL, "swto_wait");
    cyc(0, 0, 0, MWTO, NO_MW, "swto_timeout");
    cyc(0, 1, 0, F1,  ALL, "swto_back_fetch");

    // illegal opcode
    opcode = 6'b111111;
    cyc(0, 1, 0, DILL, ALL, "ill_decode");
    opcode = 6'b000000;
    cyc(0, 1, 0, F1,  ALL, "ill_back_fetch");

    // R-type aborted by async reset mid-R_EXEC
    cyc(0, 1, 0, D0,  ALL, "rst_decode");
    begin
      exp_t e;
      e.val = REX; e.mask = ALL; e.name = "rst_rexec";
      q.push_back(e);
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      n_vec++;
      if (state !== 4'd0 || dut_vec() !== ZERO) begin
        n_bad++;
        $display("FAIL async_reset: state %0d outputs %06h expected state 0 outputs 000000",
                 state, dut_vec());
      end
      @(posedge clk); #1;
    end
    cyc(1, 1, 0, ZERO, ALL, "reset2_outputs");
    cyc(0, 1, 0, F1,  ALL, "reset2_fetch");
    cyc(0, 1, 0, D0,  ALL, "reset2_decode");

    repeat (2) @(posedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
